mr_base_scheduler: RTL

//  Sequences one shared Miller-Rabin witness engine over a fixed set of bases. Bases run one at a time.

---
 rtl/mr_base_scheduler.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mr_base_scheduler.sv
// -----------------------------------------------------------------------------
// mr_base_scheduler
//
// Purpose:
//   Drives one shared Miller-Rabin witness engine over three fixed bases
//   (BASE0, BASE1, BASE2), one base at a time, and reports a single
//   probable-prime verdict per candidate. Candidates that are below 2, equal
//   to one of the bases, or even are resolved directly without the engine.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active low
//   req_valid    in   1      candidate offered
//   req_ready    out  1      high only while idle
//   req_n        in   WIDTH  candidate value
//   rsp_valid    out  1      verdict available
//   rsp_ready    in   1      consumer accepts verdict
//   rsp_prime    out  1      1 = probable prime
//   rsp_timeout  out  1      1 = engine aborted on timeout (rsp_prime = 0)
//   busy         out  1      high whenever not idle
//   base_idx     out  2      index of the base currently in use (0..2)
//   mr_rst       out  1      engine reset, active low; high only while running
//   mr_n         out  WIDTH  engine candidate
//   mr_a         out  WIDTH  engine base
//   mr_y         in   1      engine: current base proves n composite
//   mr_ret       in   1      engine: current base passes
//
// All outputs are registers. The handshake/status flags are loaded from the
// next-state value so they line up exactly with the state they describe.
// -----------------------------------------------------------------------------
module mr_base_scheduler #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned BASE0       = 2,
    parameter int unsigned BASE1       = 7,
    parameter int unsigned BASE2       = 61,
    parameter int unsigned TIMEOUT_CYC = 8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_prime,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [1:0]       base_idx,
    output logic             mr_rst,
    output logic [WIDTH-1:0] mr_n,
    output logic [WIDTH-1:0] mr_a,
    input  logic             mr_y,
    input  logic             mr_ret
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] B0           = WIDTH'(BASE0);
    localparam logic [WIDTH-1:0] B1           = WIDTH'(BASE1);
    localparam logic [WIDTH-1:0] B2           = WIDTH'(BASE2);
    localparam logic [WIDTH-1:0] TWO          = WIDTH'(2);
    localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT_CYC - 32'd1);

    // Base value selected by a base index; index 3 never occurs.
    function automatic logic [WIDTH-1:0] base_of(input logic [1:0] idx);
        logic [WIDTH-1:0] b;
        case (idx)
            2'd0:    b = B0;
            2'd1:    b = B1;
            2'd2:    b = B2;
            default: b = {WIDTH{1'b0}};
        endcase
        return b;
    endfunction

    state_t           state_r, state_n;
    logic [1:0]       base_idx_r, base_idx_n;
    logic [15:0]      cnt_r, cnt_n;
    logic             rsp_prime_r, prime_n;
    logic             rsp_timeout_r, timeout_n;
    logic [WIDTH-1:0] mr_n_r, mr_n_n;
    logic [WIDTH-1:0] mr_a_r, mr_a_n;
    logic             req_ready_r, rsp_valid_r, busy_r, mr_rst_r;
    logic [WIDTH-1:0] cur_base_s;
    logic             last_base_s;

    // Next-state, verdict, base sequencing and timeout counter logic.
    always_comb begin
        state_n     = state_r;
        base_idx_n  = base_idx_r;
        cnt_n       = cnt_r;
        prime_n     = rsp_prime_r;
        timeout_n   = rsp_timeout_r;
        mr_n_n      = mr_n_r;
        mr_a_n      = mr_a_r;
        cur_base_s  = base_of(base_idx_r);
        last_base_s = (base_idx_r == 2'd2);
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    mr_n_n  = req_n;
                    state_n = S_CHECK;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_CHECK: begin
                // Ordered: first matching rule decides.
                if (mr_n_r < TWO) begin
                    prime_n   = 1'b0;
                    timeout_n = 1'b0;
                    state_n   = S_RESP;
                end else if ((mr_n_r == B0) || (mr_n_r == B1) || (mr_n_r == B2)) begin
                    prime_n   = 1'b1;
                    timeout_n = 1'b0;
                    state_n   = S_RESP;
                end else if (mr_n_r[0] == 1'b0) begin
                    prime_n   = 1'b0;
                    timeout_n = 1'b0;
                    state_n   = S_RESP;
                end else begin
                    base_idx_n = 2'd0;
                    mr_a_n     = B0;
                    cnt_n      = 16'd0;
                    state_n    = S_LOAD;
                end
            end
            S_LOAD: begin
                // A base not below n is meaningless for the engine; skip it.
                if (cur_base_s >= mr_n_r) begin
                    if (last_base_s) begin
                        prime_n   = 1'b1;
                        timeout_n = 1'b0;
                        state_n   = S_RESP;
                    end else begin
                        base_idx_n = base_idx_r + 2'd1;
                        mr_a_n     = base_of(base_idx_r + 2'd1);
                        state_n    = S_LOAD;
                    end
                end else begin
                    cnt_n   = 16'd0;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                // Composite evidence wins over a simultaneous pass.
                if (mr_y) begin
                    prime_n   = 1'b0;
                    timeout_n = 1'b0;
                    state_n   = S_RESP;
                end else if (mr_ret) begin
                    if (last_base_s) begin
                        prime_n   = 1'b1;
                        timeout_n = 1'b0;
                        state_n   = S_RESP;
                    end else begin
                        base_idx_n = base_idx_r + 2'd1;
                        mr_a_n     = base_of(base_idx_r + 2'd1);
                        cnt_n      = 16'd0;
                        state_n    = S_LOAD;
                    end
                end else if (cnt_r == TIMEOUT_LAST) begin
                    prime_n   = 1'b0;
                    timeout_n = 1'b1;
                    state_n   = S_RESP;
                end else begin
                    cnt_n   = cnt_r + 16'd1;
                    state_n = S_RUN;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_RESP;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            base_idx_r    <= 2'd0;
            cnt_r         <= 16'd0;
            rsp_prime_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
            mr_n_r        <= {WIDTH{1'b0}};
            mr_a_r        <= {WIDTH{1'b0}};
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            mr_rst_r      <= 1'b0;
        end else begin
            state_r       <= state_n;
            base_idx_r    <= base_idx_n;
            cnt_r         <= cnt_n;
            rsp_prime_r   <= prime_n;
            rsp_timeout_r <= timeout_n;
            mr_n_r        <= mr_n_n;
            mr_a_r        <= mr_a_n;
            req_ready_r   <= (state_n == S_IDLE);
            rsp_valid_r   <= (state_n == S_RESP);
            busy_r        <= (state_n != S_IDLE);
            mr_rst_r      <= (state_n == S_RUN);
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_prime   = rsp_prime_r;
    assign rsp_timeout = rsp_timeout_r;
    assign busy        = busy_r;
    assign base_idx    = base_idx_r;
    assign mr_rst      = mr_rst_r;
    assign mr_n        = mr_n_r;
    assign mr_a        = mr_a_r;

endmodule
